// File: rtl/parity_tx_scheduler.sv
// parity_tx_scheduler: round-robin two-requester front end that encodes a
// 7-bit word into an 8-bit majority/parity codeword and shifts it out MSB first.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   a_valid/a_data/a_ctrl/a_ready  requester A handshake, word, mode
//   b_valid/b_data/b_ctrl/b_ready  requester B handshake, word, mode
//   ser_out/ser_valid           serial bit and its qualifier
//   ser_start/ser_last          frame strobes (bit 7 / bit 0)
//   ser_src                     frame source, 0=A 1=B
//   code_out                    codeword of the current/last frame
//   frame_cnt                   completed frames, wrapping
//   busy                        not idle
module parity_tx_scheduler #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [6:0]       a_data,
  input  logic             a_ctrl,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [6:0]       b_data,
  input  logic             b_ctrl,
  output logic             b_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_start,
  output logic             ser_last,
  output logic             ser_src,
  output logic [7:0]       code_out,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? int'(GAP_CYCLES) - 1 : 0);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ptr_q, ptr_d;
  logic [7:0]       code_q, code_d;
  logic             src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       grant_a, grant_b, idle;
  logic [6:0] win_data;
  logic       win_ctrl, maj, extra;

  // ptr_q holds the last winner; on contention the other side wins.
  assign grant_a  = a_valid & (~b_valid | ptr_q);
  assign grant_b  = b_valid & (~a_valid | ~ptr_q);
  assign idle     = (state_q == IDLE);
  // Readys are forced low while reset is held so every output reads 0.
  assign a_ready  = idle & rst_n & grant_a;
  assign b_ready  = idle & rst_n & grant_b;

  assign win_data = grant_b ? b_data : a_data;
  assign win_ctrl = grant_b ? b_ctrl : a_ctrl;
  // Seven bits never tie: ones-majority means four or more ones.
  assign maj      = $countones(win_data) > 3;
  assign extra    = win_ctrl ? maj : ~maj;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    code_d  = code_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_a | grant_b) begin
          code_d  = {win_data[6:4], extra, win_data[3:0]};
          src_d   = grant_b;
          ptr_d   = grant_b;
          idx_d   = 3'd7;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      gap_q   <= '0;
      ptr_q   <= 1'b1;
      code_q  <= 8'h00;
      src_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_valid = (state_q == SHIFT);
  assign ser_out   = ser_valid & code_q[idx_q];
  assign ser_start = ser_valid & (idx_q == 3'd7);
  assign ser_last  = ser_valid & (idx_q == 3'd0);
  assign ser_src   = src_q;
  assign code_out  = code_q;
  assign frame_cnt = cnt_q;
  assign busy      = ~idle;

endmodule

// File: doc/parity_tx_scheduler.md
Name: parity_tx_scheduler

Overview:
- Two-requester front end for the 7-to-8-bit majority/parity encoder.
- Arbitrates between requesters A and B round-robin, accepts one 7-bit word plus its mode bit from the winner, and encodes it into an 8-bit codeword.
- Shifts the codeword out serially, MSB first, with frame strobes.
- Sits between the data producers and the serial link driver.

Parameters:
- GAP_CYCLES, 1, idle cycles inserted after each frame's last bit (0 allowed)
- CNT_W, 8, width of the sent-frame counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  requester A has a word
- a_data  input  7  requester A word
- a_ctrl  input  1  requester A encoding mode
- a_ready  output  1  A's word accepted this cycle when a_valid is also high
- b_valid  input  1  requester B has a word
- b_data  input  7  requester B word
- b_ctrl  input  1  requester B encoding mode
- b_ready  output  1  B's word accepted this cycle when b_valid is also high
- ser_out  output  1  serial codeword bit
- ser_valid  output  1  ser_out carries a codeword bit
- ser_start  output  1  first bit (bit 7) of a frame
- ser_last  output  1  last bit (bit 0) of a frame
- ser_src  output  1  source of the current frame: 0=A, 1=B
- code_out  output  8  full codeword of the current/last frame
- frame_cnt  output  CNT_W  frames completed, wraps modulo 2^CNT_W
- busy  output  1  state != IDLE

Behaviour:
- Reset, asynchronous and immediate: all outputs 0; state IDLE; bit index 0; gap counter 0; round-robin pointer = B (so A wins first contention). Any partial frame is discarded and frame_cnt is not incremented.
- Encoding rule:
  - z = number of 0s and o = number of 1s in the 7-bit word; never equal.
  - ctrl=0: extra = 1 if z>o, else 0.
  - ctrl=1: extra = 0 if z>o, else 1.
  - codeword = {d[6:4], extra, d[3:0]}.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Grant is combinational.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - Neither valid: no grant.
  - x_ready = 1 for the granted requester only. Both readys are 0 outside IDLE.
- Accept edge (valid&ready):
  - Register the codeword into code_out and set ser_src.
  - Pointer := winner; bit index := 7; go to SHIFT.
  - The requester must hold data/ctrl stable while valid&!ready. Inputs are ignored after the accept edge.
- SHIFT:
  - ser_valid=1 and ser_out = code_out[index].
  - ser_start=1 when index=7; ser_last=1 when index=0.
  - Index decrements each cycle; the frame lasts 8 cycles.
  - At the edge leaving index 0: frame_cnt+1 (wrapping). Then go to GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - ser_valid=0, ser_out=0; lasts exactly GAP_CYCLES cycles, then IDLE.
- Latency and throughput:
  - The first bit appears the cycle after the accept edge.
  - Minimum frame period is 9+GAP_CYCLES cycles, since one IDLE cycle is needed per accept.
- Hold behaviour:
  - code_out and ser_src hold their values after a frame until the next accept.
  - ser_start and ser_last are 0 outside SHIFT.
- A valid that drops in IDLE before being accepted is simply not served; no state changes.

Test Plan:
- Reset, then A: a_data=7'b0000001, a_ctrl=0 -> a_ready=1 in IDLE; code_out=8'h11; ser_out over 8 cycles = 0,0,0,1,0,0,0,1; ser_start on cycle 1, ser_last on cycle 8; frame_cnt=1; busy high for 8+GAP_CYCLES cycles.
- Mode coverage, A only:
  - 7'h7F ctrl=0 -> 8'hEF.
  - 7'h7F ctrl=1 -> 8'hFF.
  - 7'h00 ctrl=1 -> 8'h00.
  - 7'h00 ctrl=0 -> 8'h10.
  - 7'b1010101 (o=4) ctrl=0 -> 8'hA5.
- Contention: a_valid and b_valid held high for 4 frames -> grant order A,B,A,B; ser_src=0,1,0,1; frame period 10 cycles with GAP_CYCLES=1; frame_cnt=4.
- Back-pressure: b_valid raised during an A frame -> b_ready=0 until IDLE; B accepted on the first IDLE cycle; B's data changed while waiting -> the value at accept is encoded.
- Reset mid-frame: rst_n low at bit index 4 -> all outputs 0 asynchronously; after release, frame_cnt=0 and A wins the first contention.
- Wrap: CNT_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1; GAP_CYCLES=0 -> period 9 cycles.
